// File: rtl/bus_arb_pkg.sv
// Shared types and default sizing for the tristate bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  localparam int unsigned N_REQ_DEFAULT    = 4;
  localparam int unsigned MAX_HOLD_DEFAULT = 8;
  localparam int unsigned HOLD_W           = 8;

endpackage

// File: rtl/bus_arbiter_rr_select.sv
// Round-robin search: first set req bit at or after last_owner+1, with wrap.
module rr_select
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEFAULT,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_owner,
  output logic [IW-1:0]    index,
  output logic             found
);

  // Scan from farthest to nearest so the nearest hit is the final assignment.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int unsigned i = N_REQ; i >= 1; i--) begin
      int unsigned cand;
      cand = (32'(last_owner) + i) % N_REQ;
      if (req[cand]) begin
        index = IW'(cand);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Three-state arbiter for a shared tristate bus with hold-limit preemption.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEFAULT,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy
);

  localparam int unsigned IW = $clog2(N_REQ);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              busy_q, busy_d;

  logic [IW-1:0] sel_idx;
  logic          sel_found;
  logic          others;
  logic          release_own;
  logic          expired;

  rr_select #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_select (
    .req        (req),
    .last_owner (last_q),
    .index      (sel_idx),
    .found      (sel_found)
  );

  assign others      = |(req & ~grant_q);
  assign release_own = ~req[owner_q];
  assign expired     = (hold_q == HOLD_W'(MAX_HOLD)) && others;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE, TURN: begin
        grant_d = '0;
        owner_d = '0;
        hold_d  = '0;
        state_d = IDLE;
        if (sel_found) begin
          state_d          = OWN;
          grant_d[sel_idx] = 1'b1;
          owner_d          = sel_idx;
          last_d           = sel_idx;
          hold_d           = HOLD_W'(1);
        end
      end
      OWN: begin
        // Release and expiry collapse into the same single dead cycle.
        if (release_own || expired) begin
          state_d = TURN;
          grant_d = '0;
          owner_d = '0;
          hold_d  = '0;
        end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        owner_d = '0;
        hold_d  = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule
